pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Generic elastic pipeline-stage register for the core pipeline. It replaces
//  the plain stall-hold stage registers with a valid/ready handshake, a
//  synchronous flush and an optional skid slot.
//  It sits between any two stages (e.g. execute->memory). Data is an opaque
//  WIDTH-bit packed stage struct.
//  A saturating stall counter supports performance analysis.
// PARAMETERS
//  WIDTH   64  payload width in bits (packed stage data)
//  SKID    1   1: 2-entry skid buffer, in_ready is registered; 0: single slot, in_ready combinational
//  CNT_W   32  width of the stall-cycle counter
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      upstream stage presents in_data
//  in_ready   out  1      this stage accepts in_data this cycle
//  in_data    in   WIDTH  upstream payload
//  flush      in   1      synchronous kill of all held entries (branch mispredict/trap)
//  out_valid  out  1      out_data holds a valid entry
//  out_ready  in   1      downstream accepts out_data (low = stall, like stallM)
//  out_data   out  WIDTH  payload to downstream
//  occupancy  out  2      number of held entries, 0..2
//  stat_clr   in   1      synchronous clear of stall_cnt
//  stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
// BEHAVIOUR
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Reset, asynchronous: state EMPTY, main/skid data = 0, stall_cnt = 0.
//    Outputs after reset: out_valid=0, occupancy=0, out_data=0, in_ready=1.
//  - States: EMPTY (occ 0), ONE (main valid, occ 1), FULL (main+skid valid, occ 2).
//  - out_valid = (state != EMPTY); out_data = main register. Latency in->out is 1 cycle.
//  - SKID=1: in_ready = (state != FULL), a pure register decode with no
//    combinational path from out_ready.
//  - SKID=0: in_ready = (state == EMPTY) | out_ready, and FULL is unreachable.
//  - Transitions, when flush=0:
//      EMPTY: in_fire -> ONE, main<=in_data.
//      ONE:   in_fire & out_fire -> ONE, main<=in_data.
//             out_fire only -> EMPTY.
//             in_fire only -> FULL, skid<=in_data (SKID=1 only).
//      FULL:  in_ready=0. out_fire -> ONE, main<=skid. Otherwise hold.
//  - Order is preserved: the skid entry always leaves after the main entry.
//    No entry is duplicated or dropped without flush.
//  - Flush has highest priority:
//      next state EMPTY.
//      An in_fire in the same cycle is discarded; the upstream sees it as consumed.
//      An out_fire in the same cycle counts as delivered.
//      Data registers keep their old contents; out_data is don't-care while out_valid=0.
//  - stall_cnt:
//      +1 each cycle with out_valid & ~out_ready, held at all-ones once saturated.
//      stat_clr has priority and forces 0 next cycle.
//      A cycle that has both stat_clr and a stall leaves the counter at 0.
//  - Reset mid-transfer drops all entries immediately.
//    in_ready returns to 1 and the first posedge after release may capture.
//  - in_data is sampled only on in_fire. in_data does not need to be stable otherwise.
// TESTING
//  1. Streaming, out_ready=1: in_data 1,2,3 on consecutive cycles.
//     -> out_data 1,2,3 one cycle later, occupancy stays 1, stall_cnt=0.
//  2. SKID=1 backpressure: send A=0x11 and B=0x22 with out_ready=0.
//     -> occupancy=2, in_ready=0, stall_cnt increments.
//     Raise out_ready -> A, then B, no loss and no duplicate.
//  3. Flush in FULL with in_valid=1 (C=0x33) in the same cycle.
//     -> next cycle out_valid=0, occupancy=0, C never appears at the output.
//  4. SKID=0, out_ready=0 with ONE held.
//     -> in_ready=0 combinationally. Raise out_ready -> in_ready=1 in the same cycle.
//  5. CNT_W=4, stall 20 cycles -> stall_cnt=15 and held there.
//     Assert stat_clr -> 0 next cycle.
//  6. Assert reset asynchronously mid-stream, between clock edges.
//     -> out_valid=0, occupancy=0, stall_cnt=0 immediately, before the next edge.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: valid/ready handshake, synchronous flush,
// optional skid slot and a saturating stall-cycle counter.
module pipe_stage_buf #(
    parameter int WIDTH = 64,
    parameter int SKID  = 1,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_fire, out_fire;

    // With a skid slot in_ready is a pure state decode; without one it
    // must look at out_ready so a held entry can be replaced in one cycle.
    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = (state_q != FULL);
        end else begin : g_noskid
            assign in_ready = (state_q == EMPTY) | out_ready;
        end
    endgenerate

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = (state_q == FULL) ? 2'd2 :
                       (state_q == ONE)  ? 2'd1 : 2'd0;
    assign stall_cnt = cnt_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Next-state and data-path selection; flush overrides everything but
    // leaves the data registers untouched (their contents are then stale).
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end else if (in_fire && (SKID != 0)) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end
                end
                FULL: begin
                    // Skid entry moves up behind the departing main entry.
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Stall counter: clear wins over a concurrent stall, saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (stat_clr) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State and payload registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a skid (SKID=1) and a single-slot (SKID=0)
// instance share all inputs; each is compared against a FIFO-queue model.
module tb_pipe_stage_buf;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, flush, out_ready, stat_clr;
    logic [W-1:0]  in_data;

    logic          a_in_ready, a_out_valid;
    logic [W-1:0]  a_out_data;
    logic [1:0]    a_occ;
    logic [CW-1:0] a_cnt;
    logic          b_in_ready, b_out_valid;
    logic [W-1:0]  b_out_data;
    logic [1:0]    b_occ;
    logic [CW-1:0] b_cnt;

    int ntests = 0;
    int nfail  = 0;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int ca = 0;
    int cb = 0;
    int maxc = (1 << CW) - 1;

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(W), .SKID(1), .CNT_W(CW)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .occupancy(a_occ), .stat_clr(stat_clr), .stall_cnt(a_cnt)
    );

    pipe_stage_buf #(.WIDTH(W), .SKID(0), .CNT_W(CW)) u_dut0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .occupancy(b_occ), .stat_clr(stat_clr), .stall_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare both instances against the model for the current inputs.
    task automatic check_all(input logic orr);
        chk("a_out_valid", 32'(a_out_valid), 32'(qa.size() > 0));
        chk("a_occ",       32'(a_occ),       32'(qa.size()));
        chk("a_in_ready",  32'(a_in_ready),  32'(qa.size() < 2));
        chk("a_cnt",       32'(a_cnt),       32'(ca));
        if (qa.size() > 0) chk("a_out_data", 32'(a_out_data), 32'(qa[0]));
        chk("b_out_valid", 32'(b_out_valid), 32'(qb.size() > 0));
        chk("b_occ",       32'(b_occ),       32'(qb.size()));
        chk("b_in_ready",  32'(b_in_ready),  32'(qb.size() == 0 || orr));
        chk("b_cnt",       32'(b_cnt),       32'(cb));
        if (qb.size() > 0) chk("b_out_data", 32'(b_out_data), 32'(qb[0]));
    endtask

    // One clock cycle: drive, check, then advance the model across the edge.
    task automatic cycle(input logic iv, input logic [W-1:0] d, input logic orr,
                         input logic fl, input logic clr);
        bit a_in, a_out, b_in, b_out;
        @(negedge clk);
        in_valid = iv; in_data = d; out_ready = orr; flush = fl; stat_clr = clr;
        #1;
        check_all(orr);
        a_in  = iv && (qa.size() < 2);
        a_out = (qa.size() > 0) && orr;
        b_in  = iv && (qb.size() == 0 || orr);
        b_out = (qb.size() > 0) && orr;
        @(posedge clk);
        if (clr) ca = 0; else if (qa.size() > 0 && !orr && ca < maxc) ca++;
        if (clr) cb = 0; else if (qb.size() > 0 && !orr && cb < maxc) cb++;
        if (fl) begin
            qa.delete(); qb.delete();
        end else begin
            if (a_out) void'(qa.pop_front());
            if (a_in)  qa.push_back(d);
            if (b_out) void'(qb.pop_front());
            if (b_in)  qb.push_back(d);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0;
        out_ready = 1'b0; stat_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_valid", 32'(a_out_valid), 0);
        chk("rst_a_data",  32'(a_out_data),  0);
        chk("rst_a_ready", 32'(a_in_ready),  1);
        chk("rst_b_ready", 32'(b_in_ready),  1);
        @(negedge clk);
        reset = 1'b0;

        // Streaming 1,2,3 with out_ready high
        cycle(1, 16'd1, 1, 0, 0);
        cycle(1, 16'd2, 1, 0, 0);
        cycle(1, 16'd3, 1, 0, 0);
        cycle(0, 16'd0, 1, 0, 0);
        cycle(0, 16'd0, 1, 0, 0);

        // Backpressure: A, B while stalled, then drain in order
        cycle(1, 16'h11, 0, 0, 0);
        cycle(1, 16'h22, 0, 0, 0);
        cycle(1, 16'h99, 0, 0, 0);
        chk("bp_a_occ2", 32'(a_occ), 2);
        cycle(0, 16'h0, 1, 0, 0);
        cycle(0, 16'h0, 1, 0, 0);
        cycle(0, 16'h0, 1, 0, 0);

        // Flush while FULL with a concurrent in_valid (C=0x33)
        cycle(1, 16'h11, 0, 0, 0);
        cycle(1, 16'h22, 0, 0, 0);
        cycle(1, 16'h33, 0, 1, 0);
        cycle(0, 16'h0, 1, 0, 0);
        cycle(0, 16'h0, 1, 0, 0);

        // Single-slot: held entry, in_ready follows out_ready combinationally
        cycle(1, 16'h44, 0, 0, 0);
        cycle(1, 16'h55, 0, 0, 0);
        cycle(1, 16'h55, 1, 0, 0);
        cycle(0, 16'h0, 1, 0, 0);
        cycle(0, 16'h0, 1, 0, 0);

        // Stall counter saturation then clear
        cycle(0, 16'h0, 0, 0, 1);
        cycle(1, 16'h66, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 16'h0, 0, 0, 0);
        chk("sat_a", 32'(a_cnt), 15);
        chk("sat_b", 32'(b_cnt), 15);
        cycle(0, 16'h0, 0, 0, 1);
        cycle(0, 16'h0, 0, 0, 0);
        cycle(0, 16'h0, 1, 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), W'($urandom),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 24) == 0),
                  1'($urandom_range(0, 30) == 0));
        end

        // Asynchronous reset between edges while holding entries
        cycle(1, 16'h77, 0, 0, 0);
        cycle(1, 16'h78, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_a_valid", 32'(a_out_valid), 0);
        chk("ar_a_occ",   32'(a_occ),       0);
        chk("ar_a_cnt",   32'(a_cnt),       0);
        chk("ar_a_ready", 32'(a_in_ready),  1);
        chk("ar_b_valid", 32'(b_out_valid), 0);
        chk("ar_b_cnt",   32'(b_cnt),       0);
        qa.delete(); qb.delete(); ca = 0; cb = 0;
        @(negedge clk);
        reset = 1'b0;
        cycle(1, 16'h5a, 1, 0, 0);
        cycle(0, 16'h0, 1, 0, 0);
        cycle(0, 16'h0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
